bdd_eval_engine: RTL and testbench
==================================

# bdd_eval_engine

Programmable, sequential evaluator for binary-decision-diagram output functions of the learned CPU model. Each channel is one output bit. The engine walks a node table one node per cycle over a captured input vector and returns all `OUT_N` bits together under a valid/ready handshake. Bit functions become reloadable table contents rather than fixed per-bit combinational modules, and several bits share one engine.

## Interface
Parameters:
- `IN_W`, 1894, width of the input vector `i`.
- `VAR_W`, 11, variable-index width; must satisfy 2^VAR_W >= IN_W.
- `NODE_AW`, 7, node-table address width; the table has 2^NODE_AW entries.
- `OUT_N`, 4, number of channels (output bits).
- Derived values:
  - `PTR_W` = NODE_AW+1.
  - `NODE_W` = VAR_W+2*PTR_W.
  - `CH_W` = max(1, clog2(OUT_N)).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_we`  in  1  node-table write strobe; honoured only in IDLE.
- `cfg_addr`  in  NODE_AW  node-table write address.
- `cfg_wdata`  in  NODE_W  node entry {var, lo_ptr, hi_ptr}.
- `root_we`  in  1  root-pointer write strobe; honoured only in IDLE.
- `root_idx`  in  CH_W  channel whose root pointer is written.
- `root_wdata`  in  PTR_W  root pointer.
- `in_valid`  in  1  input vector offered.
- `in_ready`  out  1  engine can accept a vector.
- `i`  in  IN_W  input vector; captured on accept.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `o`  out  OUT_N  result bits; `o[c]` is channel c.
- `err`  out  1  this result hit a loop or out-of-range variable.

## Operation
- Pointer encoding:
  - MSB=1 means a terminal pointer whose constant value is bit 0.
  - MSB=0 means a node address in bits [NODE_AW-1:0].
- Node semantics: next pointer = `ivec[var] ? hi_ptr : lo_ptr`.
- Node table:
  - Flop array with asynchronous read; it is not reset.
  - Root registers reset to {1,0} (terminal 0), so an unconfigured channel yields 0.
- FSM IDLE:
  - `in_ready`=1 and `out_valid`=0.
  - Accept on `in_valid & in_ready`: latch `i` into `ivec`, set ch=0, ptr=root[0], steps=0, clear `o` and `err`, go to WALK.
  - Config writes are applied here. A config write and an accept in the same cycle are both performed, and the walk uses the old table/roots for that cycle only.
- FSM WALK (one action per cycle):
  - Terminal pointer:
    - `o[ch]` <= ptr[0].
    - If ch==OUT_N-1, go to DONE.
    - Otherwise ch++, ptr=root[ch+1], steps=0.
  - Node pointer with steps==2^NODE_AW (cycle/loop detected):
    - `o[ch]` <= 0 and `err` <= 1.
    - Advance channel exactly as for a terminal.
  - Node pointer otherwise:
    - ptr <= selected child and steps++.
    - If var >= IN_W, the variable reads as 0 and `err` <= 1.
  - `cfg_we`/`root_we` are ignored.
  - `in_ready`=0.
- FSM DONE:
  - `out_valid`=1; `o` and `err` are held stable.
  - On `out_ready`, go to IDLE.
  - Config writes are ignored.
- steps counter is NODE_AW+1 bits wide and never wraps.

## Timing
- Reset values:
  - state=IDLE; `out_valid`=0, `o`=0, `err`=0.
  - roots = terminal 0.
  - `in_ready`=0 during any cycle with `rst` high, 1 afterwards.
- Reset mid-WALK or mid-DONE: returns to IDLE next edge. The partial result is discarded, with no `out_valid` pulse.
- Latency:
  - Channel c visiting d_c nodes costs d_c+1 WALK cycles.
  - `out_valid` rises S = sum over c of (d_c+1) edges after the accepting edge.
  - Minimum S = OUT_N, when all roots are terminal.
  - A looping channel costs 2^NODE_AW+1 cycles.
- Throughput: a new vector can be accepted no earlier than the edge after `out_valid & out_ready`. There is no overlap.
- `out_valid` stays high under `out_ready`=0 indefinitely; `o` and `err` must not change.

## Test plan
- Single-variable channel:
  - Setup: node0={var=93, lo={1,0}, hi={1,1}}, root0={0,0}, roots1..3 terminal 0.
  - i[93]=1 -> `o`=4'b0001, `err`=0, `out_valid` 5 edges after accept.
  - i[93]=0 -> `o`=0.
- Three-level chain (vars 93 -> 1722 -> 1725):
  - Sweep all 8 combinations.
  - Required response: `o[0]` matches the hand-computed function; latency = 4+3 = 7 edges.
- Loop: node5 with lo=hi=node5, root2={0,5} -> `o[2]`=0, `err`=1, latency 3+(2^7+1)=132 edges; a following clean vector gives `err`=0.
- Out-of-range var 2000 in root0 node -> read as 0, lo branch taken, `err`=1.
- Backpressure:
  - Hold `out_ready`=0 for 20 cycles -> `o`, `out_valid` stable and `in_valid` not accepted.
  - Raise `out_ready` -> IDLE and `in_ready`=1 the next cycle.
- Reset during WALK (cycle 2) -> no `out_valid`, all outputs 0, roots terminal 0; a config write in DONE is ignored (table readback via a later walk unchanged).

Source files
------------

// File: rtl/bdd_eval_engine.sv
// Sequential BDD evaluator: walks a reloadable node table one node per cycle for each of OUT_N channels.
// Latency sum(d_c+1) cycles after accept; result held under out_valid until out_ready, no overlap.
module bdd_eval_engine #(
    parameter  int IN_W    = 1894,
    parameter  int VAR_W   = 11,
    parameter  int NODE_AW = 7,
    parameter  int OUT_N   = 4,
    localparam int PTR_W   = NODE_AW + 1,
    localparam int NODE_W  = VAR_W + 2 * PTR_W,
    localparam int CH_W    = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [NODE_AW-1:0] cfg_addr,
    input  logic [NODE_W-1:0] cfg_wdata,
    input  logic              root_we,
    input  logic [CH_W-1:0]   root_idx,
    input  logic [PTR_W-1:0]  root_wdata,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_N-1:0]  o,
    output logic              err
);

    localparam int NODES = 1 << NODE_AW;

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;

    state_t              state_q;
    logic [NODE_W-1:0]   table_q [NODES];
    logic [PTR_W-1:0]    root_q  [OUT_N];
    logic [IN_W-1:0]     ivec_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [NODE_AW:0]    steps_q;
    logic [CH_W-1:0]     ch_q;
    logic [OUT_N-1:0]    o_q;
    logic                err_q;

    logic [NODE_W-1:0]   node_d;
    logic [VAR_W-1:0]    node_var;
    logic [PTR_W-1:0]    node_lo;
    logic [PTR_W-1:0]    node_hi;
    logic                var_oob;
    logic                var_bit;
    logic                is_term;
    logic                loop_hit;
    logic                last_ch;
    logic [CH_W-1:0]     ch_d;

    always_comb begin
        node_d   = table_q[ptr_q[NODE_AW-1:0]];
        node_var = node_d[NODE_W-1 -: VAR_W];
        node_lo  = node_d[2*PTR_W-1 -: PTR_W];
        node_hi  = node_d[PTR_W-1:0];
        var_oob  = int'(node_var) >= IN_W;
        var_bit  = var_oob ? 1'b0 : ivec_q[node_var];
        is_term  = ptr_q[PTR_W-1];
        // steps saturates at 2^NODE_AW, so its MSB alone flags a loop
        loop_hit = steps_q[NODE_AW];
        last_ch  = (ch_q == CH_W'(OUT_N - 1));
        ch_d     = ch_q + 1'b1;
    end

    // Node table is plain storage without reset; writes only while idle.
    always_ff @(posedge clk) begin
        if (cfg_we && state_q == S_IDLE) begin
            table_q[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            o_q     <= '0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
            steps_q <= '0;
            ch_q    <= '0;
            for (int c = 0; c < OUT_N; c++) begin
                root_q[c] <= {1'b1, {NODE_AW{1'b0}}};
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (root_we && int'(root_idx) < OUT_N) begin
                        root_q[root_idx] <= root_wdata;
                    end
                    if (in_valid) begin
                        ivec_q  <= i;
                        ch_q    <= '0;
                        ptr_q   <= root_q[0];
                        steps_q <= '0;
                        o_q     <= '0;
                        err_q   <= 1'b0;
                        state_q <= S_WALK;
                    end
                end
                S_WALK: begin
                    if (is_term || loop_hit) begin
                        o_q[ch_q] <= is_term ? ptr_q[0] : 1'b0;
                        if (!is_term) begin
                            err_q <= 1'b1;
                        end
                        if (last_ch) begin
                            state_q <= S_DONE;
                        end else begin
                            ch_q    <= ch_d;
                            ptr_q   <= root_q[ch_d];
                            steps_q <= '0;
                        end
                    end else begin
                        ptr_q   <= var_bit ? node_hi : node_lo;
                        steps_q <= steps_q + 1'b1;
                        if (var_oob) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign o         = o_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bdd_eval_engine.sv
// Bench for bdd_eval_engine: reference walk over a shadow node table, cycle-exact handshake checks.
module tb_bdd_eval_engine;

    localparam int IN_W    = 1894;
    localparam int VAR_W   = 11;
    localparam int NODE_AW = 7;
    localparam int OUT_N   = 4;
    localparam int PTR_W   = NODE_AW + 1;
    localparam int NODE_W  = VAR_W + 2 * PTR_W;
    localparam int CH_W    = 2;
    localparam int NODES   = 1 << NODE_AW;
    localparam logic [PTR_W-1:0] T0 = 8'h80;
    localparam logic [PTR_W-1:0] T1 = 8'h81;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_we = 1'b0;
    logic [NODE_AW-1:0] cfg_addr = '0;
    logic [NODE_W-1:0]  cfg_wdata = '0;
    logic               root_we = 1'b0;
    logic [CH_W-1:0]    root_idx = '0;
    logic [PTR_W-1:0]   root_wdata = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [IN_W-1:0]    i = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [OUT_N-1:0]   o;
    logic               err;

    bdd_eval_engine dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .root_we(root_we), .root_idx(root_idx), .root_wdata(root_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .i(i),
        .out_valid(out_valid), .out_ready(out_ready), .o(o), .err(err)
    );

    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_bad = 0;
    int               m_var  [NODES];
    logic [PTR_W-1:0] m_lo   [NODES];
    logic [PTR_W-1:0] m_hi   [NODES];
    logic [PTR_W-1:0] m_root [OUT_N];
    logic             exp_idle = 1'b0;
    logic             exp_done = 1'b0;
    logic [OUT_N-1:0] exp_o = '0;
    logic             exp_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(exp_idle && !rst));
        chk("out_valid", 32'(out_valid), 32'(exp_done));
        if (exp_done) begin
            chk("o", 32'(o), 32'(exp_o));
            chk("err", 32'(err), 32'(exp_err));
        end
    end

    // Result of each channel is the terminal reached by following ivec from its root.
    function automatic void model(input logic [IN_W-1:0] v, output logic [OUT_N-1:0] mo,
                                  output logic me, output int lat);
        logic [PTR_W-1:0] p;
        int d, a;
        mo = '0; me = 1'b0; lat = 0;
        for (int c = 0; c < OUT_N; c++) begin
            p = m_root[c];
            d = 0;
            while (!p[PTR_W-1] && d < NODES) begin
                a = int'(p[NODE_AW-1:0]);
                if (m_var[a] >= IN_W) begin
                    me = 1'b1;
                    p = m_lo[a];
                end else begin
                    p = v[m_var[a]] ? m_hi[a] : m_lo[a];
                end
                d++;
            end
            if (p[PTR_W-1]) mo[c] = p[0];
            else me = 1'b1;
            lat += d + 1;
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_node(input int a, input int v, input logic [PTR_W-1:0] lo, input logic [PTR_W-1:0] hi);
        cfg_we = 1'b1;
        cfg_addr = NODE_AW'(a);
        cfg_wdata = {VAR_W'(v), lo, hi};
        tick;
        cfg_we = 1'b0;
        m_var[a] = v; m_lo[a] = lo; m_hi[a] = hi;
    endtask

    task automatic cfg_root(input int c, input logic [PTR_W-1:0] p);
        root_we = 1'b1;
        root_idx = CH_W'(c);
        root_wdata = p;
        tick;
        root_we = 1'b0;
        m_root[c] = p;
    endtask

    task automatic rand_vec(output logic [IN_W-1:0] v);
        for (int k = 0; k < IN_W; k++) v[k] = 1'($urandom_range(0, 1));
    endtask

    // Accept v, expect out_valid exactly lat edges later, then hold for 'hold' cycles.
    task automatic send(input logic [IN_W-1:0] v, input int hold, input bit cfg_in_done,
                        output logic [OUT_N-1:0] mo, output logic me, output int lat);
        model(v, mo, me, lat);
        i = v;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        exp_idle = 1'b0;
        repeat (lat) tick;
        exp_done = 1'b1;
        exp_o = mo;
        exp_err = me;
        in_valid = 1'b1;
        i = ~v;
        if (cfg_in_done) begin
            cfg_we = 1'b1; cfg_addr = 7'd1; cfg_wdata = {11'd7, T1, T1};
            root_we = 1'b1; root_idx = 2'd0; root_wdata = T1;
        end
        repeat (hold) tick;
        in_valid = 1'b0;
        cfg_we = 1'b0;
        root_we = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        exp_done = 1'b0;
        exp_idle = 1'b1;
    endtask

    initial begin
        logic [IN_W-1:0]  v;
        logic [OUT_N-1:0] mo;
        logic             me;
        int               lat;
        logic [2:0]       kb;
        logic [PTR_W-1:0] lo, hi;
        int               vr;

        for (int c = 0; c < OUT_N; c++) m_root[c] = T0;
        for (int n = 0; n < NODES; n++) begin m_var[n] = 0; m_lo[n] = T0; m_hi[n] = T0; end

        repeat (3) tick;
        rst = 1'b0;
        exp_idle = 1'b1;
        chk("reset_o", 32'(o), 32'h0);
        chk("reset_err", 32'(err), 32'h0);

        // Single-variable channel, with 20 cycles of backpressure.
        cfg_node(0, 93, T0, T1);
        cfg_root(0, 8'h00);
        rand_vec(v); v[93] = 1'b1;
        send(v, 20, 1'b0, mo, me, lat);
        chk("single_hi_o", 32'(mo), 32'h1);
        chk("single_hi_err", 32'(me), 32'h0);
        chk("single_lat", 32'(lat), 32'd5);
        rand_vec(v); v[93] = 1'b0;
        send(v, 0, 1'b0, mo, me, lat);
        chk("single_lo_o", 32'(mo), 32'h0);

        // Three-level chain: o[0] = i93 ^ i1722 ^ i1725.
        cfg_node(1, 93, 8'h02, 8'h03);
        cfg_node(2, 1722, 8'h04, 8'h05);
        cfg_node(3, 1722, 8'h05, 8'h04);
        cfg_node(4, 1725, T0, T1);
        cfg_node(5, 1725, T1, T0);
        cfg_root(0, 8'h01);
        for (int k = 0; k < 8; k++) begin
            kb = 3'(k);
            rand_vec(v);
            v[93] = kb[0]; v[1722] = kb[1]; v[1725] = kb[2];
            send(v, k % 3, 1'b0, mo, me, lat);
            chk("chain_o", 32'(mo), 32'(^kb));
            chk("chain_lat", 32'(lat), 32'd7);
        end

        // Config writes during DONE must not land in the table or roots.
        rand_vec(v); v[93] = 1'b0; v[1722] = 1'b0; v[1725] = 1'b1;
        send(v, 3, 1'b1, mo, me, lat);
        rand_vec(v); v[93] = 1'b0; v[1722] = 1'b0; v[1725] = 1'b0;
        send(v, 0, 1'b0, mo, me, lat);
        chk("done_cfg_o", 32'(mo), 32'h0);

        // Reset two cycles into a walk.
        rand_vec(v);
        i = v;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        exp_idle = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_idle = 1'b1;
        for (int c = 0; c < OUT_N; c++) m_root[c] = T0;
        chk("midreset_o", 32'(o), 32'h0);
        chk("midreset_err", 32'(err), 32'h0);
        repeat (3) tick;
        send(v, 1, 1'b0, mo, me, lat);
        chk("postreset_o", 32'(mo), 32'h0);
        chk("postreset_lat", 32'(lat), 32'd4);

        // Out-of-range variable takes lo branch and flags err.
        cfg_node(0, 2000, T1, T0);
        cfg_root(0, 8'h00);
        rand_vec(v);
        send(v, 0, 1'b0, mo, me, lat);
        chk("oob_o", 32'(mo), 32'h1);
        chk("oob_err", 32'(me), 32'h1);

        // Self-loop on channel 2, then a clean vector.
        cfg_root(0, T0);
        cfg_node(5, 10, 8'h05, 8'h05);
        cfg_root(2, 8'h05);
        rand_vec(v);
        send(v, 2, 1'b0, mo, me, lat);
        chk("loop_o", 32'(mo), 32'h0);
        chk("loop_err", 32'(me), 32'h1);
        chk("loop_lat", 32'(lat), 32'd132);
        cfg_root(2, T1);
        send(v, 0, 1'b0, mo, me, lat);
        chk("clean_o", 32'(mo), 32'h4);
        chk("clean_err", 32'(me), 32'h0);

        // Random tables: mostly forward DAGs, occasional back-edges and out-of-range vars.
        for (int n = NODES - 1; n >= 0; n--) begin
            vr = ($urandom_range(0, 15) == 0) ? int'($urandom_range(IN_W, 2047)) : int'($urandom_range(0, IN_W - 1));
            for (int s = 0; s < 2; s++) begin
                if (n == NODES - 1 || $urandom_range(0, 2) == 0) lo = {1'b1, 6'd0, 1'($urandom_range(0, 1))};
                else if ($urandom_range(0, 19) == 0) lo = {1'b0, 7'($urandom_range(0, NODES - 1))};
                else lo = {1'b0, 7'($urandom_range(n + 1, NODES - 1))};
                if (s == 0) hi = lo;
            end
            cfg_node(n, vr, lo, hi);
        end
        for (int t = 0; t < 25; t++) begin
            for (int c = 0; c < OUT_N; c++) begin
                if ($urandom_range(0, 5) == 0) cfg_root(c, {1'b1, 6'd0, 1'($urandom_range(0, 1))});
                else cfg_root(c, {1'b0, 7'($urandom_range(0, 40))});
            end
            rand_vec(v);
            send(v, int'($urandom_range(0, 3)), 1'b0, mo, me, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
